// File: rtl/strip_frame_seq.sv
// Frame sequencer feeding the doled LED serializer: START, one LED per pixel, END_FRAMES ENDs.
// Optional periodic self-refresh when STRIP_AUTO_REFRESH_EN is defined.
module strip_frame_seq #(
  parameter int NUM_LEDS       = 60,
  parameter int ADDR_W         = 6,
`ifdef STRIP_AUTO_REFRESH_EN
  parameter int END_FRAMES     = 4,
  parameter int REFRESH_CYCLES = 1000000
`else
  parameter int END_FRAMES     = 4
`endif
) (
  input  logic              doled_clk,
  input  logic              doled_reset,
  input  logic              pix_we,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  input  logic              frame_start,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              seq_start,
  output logic [1:0]        seq_type,
  output logic [7:0]        seq_blue,
  output logic [7:0]        seq_green,
  output logic [7:0]        seq_red,
  input  logic              seq_busy
);

  localparam int RAM_AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [1:0] TY_START = 2'd0;
  localparam logic [1:0] TY_LED   = 2'd1;
  localparam logic [1:0] TY_END   = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    ADVANCE   = 3'd3,
    FETCH     = 3'd4,
    LATCH     = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t            state;
  logic              pending;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        end_cnt;
  logic [23:0]       ram [2**RAM_AW];
  logic [23:0]       ram_q;
  logic              pix_in_range;
  logic              refresh_hit;

  // Extra bit keeps the bound correct when NUM_LEDS == 2**ADDR_W.
  assign pix_in_range = {1'b0, pix_addr} < (ADDR_W+1)'(NUM_LEDS);

  always_ff @(posedge doled_clk) begin
    if (pix_we && pix_in_range)
      ram[pix_addr[RAM_AW-1:0]] <= pix_data;
  end

  always_ff @(posedge doled_clk) begin
    if (state == FETCH)
      ram_q <= ram[idx[RAM_AW-1:0]];
  end

`ifdef STRIP_AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  logic [RW-1:0] refresh_cnt;

  assign refresh_hit = !frame_busy && (refresh_cnt == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge doled_clk or posedge doled_reset) begin
    if (doled_reset)
      refresh_cnt <= '0;
    else if (frame_busy || refresh_hit)
      refresh_cnt <= '0;
    else
      refresh_cnt <= refresh_cnt + 1'b1;
  end
`else
  assign refresh_hit = 1'b0;
`endif

  always_ff @(posedge doled_clk or posedge doled_reset) begin
    if (doled_reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      idx        <= '0;
      end_cnt    <= '0;
      seq_start  <= 1'b0;
      seq_type   <= TY_START;
      seq_red    <= '0;
      seq_green  <= '0;
      seq_blue   <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Requests during a frame (including its DONE cycle) merge into one pending frame.
      if ((frame_start && frame_busy) || refresh_hit)
        pending <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_start || pending) begin
            frame_busy <= 1'b1;
            pending    <= 1'b0;
            seq_type   <= TY_START;
            seq_red    <= '0;
            seq_green  <= '0;
            seq_blue   <= '0;
            seq_start  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (seq_busy) begin
            seq_start <= 1'b0;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!seq_busy)
            state <= ADVANCE;
        end
        ADVANCE: begin
          case (seq_type)
            TY_START: begin
              idx   <= '0;
              state <= FETCH;
            end
            TY_LED: begin
              if (idx == ADDR_W'(NUM_LEDS - 1)) begin
                end_cnt   <= '0;
                seq_type  <= TY_END;
                seq_red   <= 8'hFF;
                seq_green <= 8'hFF;
                seq_blue  <= 8'hFF;
                seq_start <= 1'b1;
                state     <= ISSUE;
              end else begin
                idx   <= idx + 1'b1;
                state <= FETCH;
              end
            end
            default: begin
              if (end_cnt == 4'(END_FRAMES - 1)) begin
                state <= DONE;
              end else begin
                end_cnt   <= end_cnt + 1'b1;
                seq_start <= 1'b1;
                state     <= ISSUE;
              end
            end
          endcase
        end
        FETCH: state <= LATCH;
        LATCH: begin
          {seq_red, seq_green, seq_blue} <= ram_q;
          seq_type  <= TY_LED;
          seq_start <= 1'b1;
          state     <= ISSUE;
        end
        DONE: begin
          frame_done <= 1'b1;
          frame_busy <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          seq_start <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
